// File: rtl/i2s_apb_feeder.sv
// -----------------------------------------------------------------------------
// i2s_apb_feeder
//
// Feeds a PCM sample stream into the Tx data register of an I2S transceiver
// through a minimal APB-style master. Every bus transfer is one setup cycle
// (penable=0) followed by one access cycle (penable=1), with no wait states.
// Before each write the transceiver flags register is polled. A word is
// written only when the Tx data register reports empty.
//
// Optional feature, guarded by the macro I2S_FEEDER_RX_DRAIN_EN:
//   When defined, the feeder also drains the transceiver Rx data register
//   into an output stream. An Rx read takes priority over a Tx write. With
//   the macro undefined, the Rx states do not exist, m_valid/m_data are
//   tied low and m_ready is ignored.
//
// Parameters:
//   ADR_BASE      byte base address of the transceiver register block
//   TX_OFFSET     Tx data register offset
//   RX_OFFSET     Rx data register offset
//   FLAGS_OFFSET  flags register offset (bit11 Tx empty, bit10 Rx empty)
//
// Ports:
//   pclk, preset      clock (rising edge) and asynchronous active-low reset
//   en                enable; when low, no new transaction is started
//   s_valid/s_ready   sample input handshake, s_data 32-bit sample
//   penable, pwrite   APB-style control (no psel, no pready)
//   paddr, pwdata     APB address / write data (held in IDLE)
//   prdata            APB read data
//   m_valid/m_ready   received-sample output handshake, m_data 32-bit word
//   wr_count          number of words written to the Tx register (wraps)
//   busy              high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module i2s_apb_feeder #(
    parameter logic [31:0] ADR_BASE     = 32'd0,
    parameter logic [31:0] TX_OFFSET    = 32'd4,
    parameter logic [31:0] RX_OFFSET    = 32'd8,
    parameter logic [31:0] FLAGS_OFFSET = 32'd12
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        en,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    output logic [15:0] wr_count,
    output logic        busy
);

    localparam logic [31:0] TX_ADDR    = ADR_BASE + TX_OFFSET;
    localparam logic [31:0] RX_ADDR    = ADR_BASE + RX_OFFSET;
    localparam logic [31:0] FLAGS_ADDR = ADR_BASE + FLAGS_OFFSET;

    localparam int TX_EMPTY_BIT = 11;
    localparam int RX_EMPTY_BIT = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POLL_S = 3'd1,
        POLL_A = 3'd2,
        WR_S   = 3'd3,
        WR_A   = 3'd4
`ifdef I2S_FEEDER_RX_DRAIN_EN
        ,
        RD_S   = 3'd5,
        RD_A   = 3'd6
`endif
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        buf_full;
    logic [31:0] buf_q;
    logic [31:0] paddr_nxt;
    logic [31:0] pwdata_nxt;
    logic        rx_want;
    logic        wr_done;

    assign s_ready = !buf_full;
    assign busy    = (state != IDLE);
    assign wr_done = (state == WR_A);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // en is only consulted in IDLE, so a transfer already under way always
    // runs to completion (including the write/read chosen after a poll).
    // NOTE: every combinational output gets a default first so that no path
    // through the case statement leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en && (buf_full || rx_want)) begin
                    state_nxt = POLL_S;
                end
            end
            POLL_S: state_nxt = POLL_A;
            POLL_A: begin
                // Flags are sampled from prdata on the edge that ends POLL_A.
                // An Rx read takes priority over a Tx write.
`ifdef I2S_FEEDER_RX_DRAIN_EN
                if (rx_want && !prdata[RX_EMPTY_BIT]) begin
                    state_nxt = RD_S;
                end else
`endif
                if (buf_full && prdata[TX_EMPTY_BIT]) begin
                    state_nxt = WR_S;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WR_S: state_nxt = WR_A;
            WR_A: state_nxt = IDLE;
`ifdef I2S_FEEDER_RX_DRAIN_EN
            RD_S: state_nxt = RD_A;
            RD_A: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // -------------------------------------------------------------------------
    // penable/pwrite decode the current state directly, so reset forces both
    // low asynchronously. paddr/pwdata are registered. They load on entry to
    // a setup state and otherwise hold, which keeps the last values in IDLE.
    always_comb begin
        penable    = 1'b0;
        pwrite     = 1'b0;
        paddr_nxt  = paddr;
        pwdata_nxt = pwdata;

        case (state)
            POLL_A, WR_A: penable = 1'b1;
`ifdef I2S_FEEDER_RX_DRAIN_EN
            RD_A:         penable = 1'b1;
`endif
            default:      penable = 1'b0;
        endcase

        pwrite = (state == WR_S) || (state == WR_A);

        case (state_nxt)
            POLL_S: paddr_nxt = FLAGS_ADDR;
            WR_S: begin
                paddr_nxt  = TX_ADDR;
                pwdata_nxt = buf_q;
            end
`ifdef I2S_FEEDER_RX_DRAIN_EN
            RD_S:   paddr_nxt = RX_ADDR;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            paddr  <= '0;
            pwdata <= '0;
        end else begin
            paddr  <= paddr_nxt;
            pwdata <= pwdata_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Sample buffer
    // -------------------------------------------------------------------------
    // s_ready stays low through WR_A. The earliest refill is therefore the
    // edge after WR_A, and clear and capture can never coincide.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            buf_full <= 1'b0;
        end else if (wr_done) begin
            buf_full <= 1'b0;
        end else if (s_valid && s_ready) begin
            buf_full <= 1'b1;
        end
    end

    // NOTE: the data word itself needs no reset. It is only observed while
    // buf_full is set, and buf_full is reset.
    always_ff @(posedge pclk) begin
        if (s_valid && s_ready) begin
            buf_q <= s_data;
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            wr_count <= '0;
        end else if (wr_done) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Optional Rx drain path
    // -------------------------------------------------------------------------
`ifdef I2S_FEEDER_RX_DRAIN_EN
    // Only drain while the output slot is free. This keeps m_data stable
    // until it is consumed, and a stalled consumer blocks further reads.
    assign rx_want = !m_valid;

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (state == RD_A) begin
            m_valid <= 1'b1;
            m_data  <= prdata;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end
`else
    assign rx_want = 1'b0;
    assign m_valid = 1'b0;
    assign m_data  = '0;

    // Inputs and constants that only the Rx path consumes.
    logic unused_rx_sink;
    assign unused_rx_sink = ^{m_ready, prdata[31:TX_EMPTY_BIT+1],
                              prdata[RX_EMPTY_BIT:0], RX_ADDR};
`endif

endmodule

// File: tb/tb_i2s_apb_feeder.sv
// -----------------------------------------------------------------------------
// tb_i2s_apb_feeder
//
// Self-checking bench for i2s_apb_feeder. Expected Tx words are queued when a
// sample is handed to the DUT and popped when the DUT writes the Tx register.
// A small responder model answers flag polls and Rx reads.
// -----------------------------------------------------------------------------
module tb_i2s_apb_feeder;

    localparam logic [31:0] TX_ADDR    = 32'd4;
    localparam logic [31:0] RX_ADDR    = 32'd8;
    localparam logic [31:0] FLAGS_ADDR = 32'd12;

    logic        pclk = 1'b0;
    logic        preset;
    logic        en;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic [15:0] wr_count;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [15:0] exp_cnt = 16'd0;

    // Responder state: Tx reports "not empty" for the first tx_busy_polls
    // polls counted from poll_base.
    int          poll_idx      = 0;
    int          poll_base     = 0;
    int          tx_busy_polls = 0;
    int          acc_seen      = 0;
    int          rd_seen       = 0;
    int          wr_seen       = 0;
    int          wr_rd_snap    = 0;
    logic        rx_empty      = 1'b1;
    logic [31:0] rx_word       = 32'h1357_9BDF;
    logic [31:0] flags;

    i2s_apb_feeder dut (
        .pclk     (pclk),
        .preset   (preset),
        .en       (en),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .wr_count (wr_count),
        .busy     (busy)
    );

    always #5 pclk = ~pclk;

    always_comb begin
        flags     = '0;
        flags[11] = ((poll_idx - poll_base) > tx_busy_polls);
        flags[10] = rx_empty;
    end

    assign prdata = (paddr == FLAGS_ADDR) ? flags :
                    (paddr == RX_ADDR)    ? rx_word : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus monitor and scoreboard, sampled mid-cycle.
    always @(negedge pclk) begin
        if (preset) begin
            if (busy && !penable && !pwrite && paddr == FLAGS_ADDR) poll_idx++;
            if (penable) acc_seen++;
            if (penable && !pwrite && paddr == RX_ADDR) rd_seen++;
            if (penable && pwrite) begin
                wr_seen++;
                wr_rd_snap = rd_seen;
                check("wr_addr", paddr, TX_ADDR);
                check("wr_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("wr_data", pwdata, exp_q.pop_front());
            end
`ifndef I2S_FEEDER_RX_DRAIN_EN
            if (busy) check("s_ready_busy", s_ready, 0);
`endif
        end
    end

    // Called at a negedge. Waits for s_ready, then offers one sample for one cycle.
    task automatic send_sample(input logic [31:0] d);
        int n = 0;
        while (!s_ready && n < 100) begin
            @(negedge pclk);
            n++;
        end
        check("send_ready", s_ready, 1);
        s_valid = 1'b1;
        s_data  = d;
        exp_q.push_back(d);
        @(negedge pclk);
        s_valid = 1'b0;
    endtask

    // Waits for the next Tx write, then lets the counter update.
    task automatic wait_write(input string tag);
        int target = wr_seen + 1;
        int n = 0;
        while (wr_seen < target && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check({tag, "_done"}, wr_seen >= target, 1);
        @(negedge pclk);
    endtask

    initial begin
        int n;
        int acc_base;
        int rd_base;

        preset  = 1'b0;
        en      = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge pclk);
        check("rst_s_ready", s_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_m_valid", m_valid, 0);
        preset = 1'b1;

        // Single sample, cycle-exact bus sequence
`ifndef I2S_FEEDER_RX_DRAIN_EN
        s_valid = 1'b1;
        s_data  = 32'hA5A5_1234;
        exp_q.push_back(32'hA5A5_1234);
        @(negedge pclk);
        s_valid = 1'b0;
        check("c1_s_ready", s_ready, 0);
        check("c1_busy", busy, 0);
        @(negedge pclk);
        check("c2_busy", busy, 1);
        check("c2_paddr", paddr, FLAGS_ADDR);
        check("c2_penable", penable, 0);
        check("c2_pwrite", pwrite, 0);
        @(negedge pclk);
        check("c3_penable", penable, 1);
        check("c3_paddr", paddr, FLAGS_ADDR);
        @(negedge pclk);
        check("c4_paddr", paddr, TX_ADDR);
        check("c4_pwrite", pwrite, 1);
        check("c4_penable", penable, 0);
        @(negedge pclk);
        check("c5_penable", penable, 1);
        check("c5_pwrite", pwrite, 1);
        check("c5_pwdata", pwdata, 32'hA5A5_1234);
        @(negedge pclk);
        exp_cnt = 16'd1;
        check("c6_wr_count", wr_count, exp_cnt);
        check("c6_s_ready", s_ready, 1);
        check("c6_busy", busy, 0);
        check("c6_penable", penable, 0);
`else
        send_sample(32'hA5A5_1234);
        wait_write("first");
        exp_cnt = 16'd1;
        check("first_wr_count", wr_count, exp_cnt);
`endif

        // Tx register busy for three polls
        poll_base     = poll_idx;
        tx_busy_polls = 3;
        send_sample(32'h1111_2222);
        wait_write("stall");
        exp_cnt++;
        check("stall_wr_count", wr_count, exp_cnt);
`ifndef I2S_FEEDER_RX_DRAIN_EN
        check("stall_polls", poll_idx - poll_base, 4);
`endif
        tx_busy_polls = 0;

        // Counter wrap, preset near the top
        force dut.wr_count = 16'hFFFE;
        @(negedge pclk);
        release dut.wr_count;
        exp_cnt = 16'hFFFE;
        send_sample(32'h0000_FFFF);
        wait_write("wrap_a");
        exp_cnt++;
        check("wrap_ffff", wr_count, exp_cnt);
        send_sample(32'hFFFF_0000);
        wait_write("wrap_b");
        exp_cnt++;
        check("wrap_zero", wr_count, exp_cnt);

        // Reset pulse during WR_A abandons the transfer
        send_sample(32'hCAFE_0033);
        n = 0;
        while (!(penable && pwrite) && n < 100) begin
            @(negedge pclk);
            n++;
        end
        check("rst_reach_wra", penable && pwrite, 1);
        #1 preset = 1'b0;
        #1;
        check("rstwr_penable", penable, 0);
        check("rstwr_pwrite", pwrite, 0);
        check("rstwr_s_ready", s_ready, 1);
        check("rstwr_busy", busy, 0);
        check("rstwr_wr_count", wr_count, exp_cnt);
        @(negedge pclk);
        preset   = 1'b1;
        acc_base = acc_seen;
        repeat (10) @(negedge pclk);
`ifndef I2S_FEEDER_RX_DRAIN_EN
        check("rstwr_quiet", acc_seen - acc_base, 0);
        check("rstwr_idle", busy, 0);
`endif

        // en dropped during POLL_A
        send_sample(32'h0340_0034);
        n = 0;
        while (!(penable && !pwrite && paddr == FLAGS_ADDR) && n < 100) begin
            @(negedge pclk);
            n++;
        end
        check("en_reach_polla", penable && paddr == FLAGS_ADDR, 1);
        en = 1'b0;
        wait_write("en_drop");
        exp_cnt++;
        check("en_drop_wr_count", wr_count, exp_cnt);
        repeat (3) @(negedge pclk);
        check("en_drop_idle", busy, 0);
        send_sample(32'h0340_0035);
        acc_base = acc_seen;
        repeat (10) @(negedge pclk);
        check("en_off_idle", busy, 0);
        check("en_off_kept", s_ready, 0);
        check("en_off_quiet", acc_seen - acc_base, 0);
        en = 1'b1;
        wait_write("en_back");
        exp_cnt++;
        check("en_back_wr_count", wr_count, exp_cnt);

`ifdef I2S_FEEDER_RX_DRAIN_EN
        // Rx read takes priority and a stalled consumer blocks further reads
        en = 1'b0;
        repeat (5) @(negedge pclk);
        send_sample(32'h5A5A_0031);
        rx_empty = 1'b0;
        rd_base  = rd_seen;
        en       = 1'b1;
        wait_write("rx_first");
        exp_cnt++;
        check("rx_rd_before_wr", wr_rd_snap - rd_base, 1);
        check("rx_m_valid", m_valid, 1);
        check("rx_m_data", m_data, rx_word);
        send_sample(32'h5A5A_0032);
        wait_write("rx_blocked");
        exp_cnt++;
        check("rx_blocked_reads", rd_seen - rd_base, 1);
        check("rx_m_data_hold", m_data, rx_word);
        check("rx_wr_count", wr_count, exp_cnt);
        rx_empty = 1'b1;
        m_ready  = 1'b1;
        @(negedge pclk);
        m_ready = 1'b0;
        @(negedge pclk);
        check("rx_m_valid_clr", m_valid, 0);
`else
        // Without the Rx path the output stream stays quiet
        m_ready = 1'b1;
        repeat (3) @(negedge pclk);
        check("norx_m_valid", m_valid, 0);
        check("norx_m_data", m_data, 0);
        m_ready = 1'b0;
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
